timer_irq: RTL and testbench
============================

# timer_irq

Memory-mapped interval timer and interrupt source for the single-cycle MIPS core. It sits on the data-memory bus beside data RAM and answers `lw`/`sw` in the peripheral window at 0x4000_0000. On counter overflow it raises `irqout`, which the core feeds to its control unit as `IRQ` to force the interrupt PC path and write the return address to `$k0` (reg 26). It is the producing end of the IRQ line that the control decoder consumes.

## Interface
- `ADDR_BASE`, 32'h4000_0000: base of the peripheral window.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `MemRd`  in  1: load strobe from the core, same cycle as `addr`.
- `MemWr`  in  1: store strobe; the write commits at the next rising `clk`.
- `addr`  in  32: byte address, word-aligned. Bits [1:0] are ignored.
- `wdata`  in  32: store data.
- `rdata`  out  32: load data, combinational.
- `irqout`  out  1: interrupt request to the core.

## Operation
- Register map (offset from `ADDR_BASE`):
  - 0x00 TH: reload value.
  - 0x04 TL: counter.
  - 0x08 TCON: [0] EN count enable, [1] IE interrupt enable, [2] IS interrupt status; [31:3] read 0.
  - 0x0C PSC: prescale, 16 bits, only with the macro.
  - 0x10 SYSTICK: free-running cycle count, read-only.
- Tick generation: when EN=1, a tick occurs every PSC+1 cycles. PSC=0 gives a tick every cycle.
- On each tick:
  - TL≠0xFFFF_FFFF: TL←TL+1.
  - TL=0xFFFF_FFFF: TL←TH, and IS←1 if IE=1.
- EN=0 freezes TL and the prescale count. The prescale count is not reset by EN.
- `irqout` = IE & IS. Software clears IS by writing TCON with bit 2 = 0; the handler must do this before `jr $k0`.
- SYSTICK increments every cycle regardless of EN and wraps 0xFFFF_FFFF→0.
- Reads:
  - `rdata` = selected register when `MemRd`=1 and `addr` is in the window.
  - Otherwise `rdata` = 0, including unmapped offsets.
- Writes to unmapped offsets and to SYSTICK are ignored.
- Collision rules:
  - Store to TL in a tick cycle: the store wins and no overflow is taken that cycle.
  - Store to TCON clearing IS in the same cycle an overflow sets IS: the set wins, so no interrupt is lost.
  - Store to TH in an overflow cycle: TL reloads the old TH.

## Timing
- Reset values: TH, TL, TCON, PSC, SYSTICK, prescale count, `irqout` all 0. `rdata` is 0 because it is combinational from the cleared state.
- Reset asserted mid-count clears all state immediately; counting resumes only after software sets EN.
- Read latency: 0 cycles (combinational in the load cycle). A store's value is visible to a load in the following cycle.
- Overflow to interrupt: IS and `irqout` assert 1 cycle after the edge on which TL = 0xFFFF_FFFF is ticked.
- Interrupt lifetime: `irqout` holds until the TCON store edge that clears IS or IE. Kernel-mode masking of IRQ is the core's job, not this block's.
- Interrupt period, with the reload write taken as cycle 0: (0xFFFF_FFFF − TH + 1)·(PSC+1) ticks of `clk`.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - PSC is implemented at offset 0x0C (read/write, bits [15:0]; [31:16] read 0).
  - The 16-bit prescale counter is instantiated.
- Not defined:
  - A tick occurs every cycle while EN=1.
  - Offset 0x0C reads 0 and ignores writes.
  - No prescale flops are built.

## Structure
- Shared package `periph_pkg` holds:
  - `ADDR_BASE`.
  - Offsets `OFF_TH`, `OFF_TL`, `OFF_TCON`, `OFF_PSC`, `OFF_SYSTICK`.
  - TCON bit indices `TCON_EN`, `TCON_IE`, `TCON_IS`.
  - Type `tcon_t`.
- Sub-module `timer_prescaler`:
  - Inputs: `clk`, `reset`, `en`, `psc[15:0]`.
  - Output: `tick`.
  - Compiled only under `TIMER_PRESCALE_EN`; otherwise `tick` = EN.
- Address decode, register file, reload logic and read mux stay in the top module.

## Test plan
- Reset check: assert `reset`=0 mid-count, then read all offsets → every read returns 0 and `irqout`=0.
- Basic overflow, macro off: TH=0xFFFF_FFFC, TL=0xFFFF_FFFC, TCON=0x3 → TL reads …FD, …FE, …FF, then reloads …FC; `irqout`=1 one cycle after the wrap edge. Writing TCON=0x3 drops `irqout` the next cycle.
- Set-wins collision: store TCON=0x3 on the exact cycle of an overflow with IE=1 → IS stays 1 and `irqout` stays 1.
- Store-to-TL collision: store TL=0x10 on a would-be overflow tick → TL=0x10 and IS stays 0.
- Prescale, macro on: PSC=3, TL=0xFFFF_FFFE, TCON=0x3 → TL steps every 4 cycles; `irqout` rises 8 cycles after EN is set.
- Bus decode: load from 0x4000_0018 or 0x1000_0000 → `rdata`=0. Store to SYSTICK → no change. Back-to-back SYSTICK reads differ by exactly 1.

Source files
------------

// File: rtl/periph_pkg.sv
// Shared definitions for the memory-mapped timer peripheral window.
// PSC at OFF_PSC exists only when TIMER_PRESCALE_EN is defined.
package periph_pkg;

  localparam logic [31:0] ADDR_BASE = 32'h4000_0000;

  localparam logic [7:0] OFF_TH      = 8'h00;
  localparam logic [7:0] OFF_TL      = 8'h04;
  localparam logic [7:0] OFF_TCON    = 8'h08;
  localparam logic [7:0] OFF_PSC     = 8'h0C;
  localparam logic [7:0] OFF_SYSTICK = 8'h10;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;

  typedef struct packed {
    logic is;
    logic ie;
    logic en;
  } tcon_t;

  // The window spans 256 bytes; anything outside it is not this peripheral.
  function automatic logic in_window(input logic [31:0] a);
    return a[31:8] == ADDR_BASE[31:8];
  endfunction

endpackage

// File: rtl/timer_irq_if.sv
// Data-memory bus as seen by the timer: load/store strobes, address, data, IRQ.
interface timer_irq_if;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irqout;

  modport master (output MemRd, MemWr, addr, wdata, input rdata, irqout);
  modport slave  (input MemRd, MemWr, addr, wdata, output rdata, irqout);
endinterface

// File: rtl/timer_prescaler.sv
// Tick divider for the timer; built only when TIMER_PRESCALE_EN is defined.
// Emits one tick every psc+1 enabled cycles; the count holds while en is low.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] psc,
  output logic        tick
);

  logic [15:0] r_cnt;

  // >= rather than == so lowering psc below the running count cannot stall for a full wrap.
  assign tick = en & (r_cnt >= psc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/timer_irq.sv
// Memory-mapped interval timer and IRQ source at ADDR_BASE on the data bus.
// Define TIMER_PRESCALE_EN to build the PSC register and the prescaler.
module timer_irq
  import periph_pkg::*;
(
  input logic       clk,
  input logic       reset,
  timer_irq_if.slave bus
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  tcon_t       r_tcon;
  logic [31:0] r_systick;

  logic [31:0] w_tl_d;
  tcon_t       w_tcon_d;
  logic [31:0] w_rdata;
  logic        w_hit;
  logic [7:0]  w_off;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;
  logic        w_tick;
  logic        w_tl_max;
  logic        w_ovf;
  logic        w_unused;

  assign w_hit     = in_window(bus.addr);
  assign w_off     = {bus.addr[7:2], 2'b00};
  assign w_wr_th   = bus.MemWr & w_hit & (w_off == OFF_TH);
  assign w_wr_tl   = bus.MemWr & w_hit & (w_off == OFF_TL);
  assign w_wr_tcon = bus.MemWr & w_hit & (w_off == OFF_TCON);
  assign w_unused  = ^bus.addr[1:0];

`ifdef TIMER_PRESCALE_EN
  logic [15:0] r_psc;
  logic        w_wr_psc;

  assign w_wr_psc = bus.MemWr & w_hit & (w_off == OFF_PSC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_psc <= '0;
    end else if (w_wr_psc) begin
      r_psc <= bus.wdata[15:0];
    end
  end

  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (r_tcon.en),
    .psc   (r_psc),
    .tick  (w_tick)
  );
`else
  assign w_tick = r_tcon.en;
`endif

  assign w_tl_max = &r_tl;
  // A store to TL owns that cycle, so it also cancels any overflow.
  assign w_ovf    = w_tick & w_tl_max & ~w_wr_tl;

  always_comb begin
    w_tl_d = r_tl;
    if (w_wr_tl) begin
      w_tl_d = bus.wdata;
    end else if (w_tick) begin
      w_tl_d = w_tl_max ? r_th : r_tl + 32'd1;
    end
  end

  always_comb begin
    w_tcon_d = r_tcon;
    if (w_wr_tcon) begin
      w_tcon_d = tcon_t'(bus.wdata[2:0]);
    end
    // Overflow set beats a same-cycle software clear so no interrupt is lost.
    if (w_ovf && r_tcon.ie) begin
      w_tcon_d.is = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th      <= '0;
      r_tl      <= '0;
      r_tcon    <= '0;
      r_systick <= '0;
    end else begin
      if (w_wr_th) begin
        r_th <= bus.wdata;
      end
      r_tl      <= w_tl_d;
      r_tcon    <= w_tcon_d;
      r_systick <= r_systick + 32'd1;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.MemRd && w_hit) begin
      case (w_off)
        OFF_TH:      w_rdata = r_th;
        OFF_TL:      w_rdata = r_tl;
        OFF_TCON:    w_rdata = {29'd0, r_tcon};
`ifdef TIMER_PRESCALE_EN
        OFF_PSC:     w_rdata = {16'd0, r_psc};
`endif
        OFF_SYSTICK: w_rdata = r_systick;
        default:     w_rdata = '0;
      endcase
    end
  end

  assign bus.rdata  = w_rdata;
  assign bus.irqout = r_tcon.ie & r_tcon.is;

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: reset, overflow/reload, collisions, decode, SYSTICK, prescale.
module tb_timer_irq;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_PSC  = 32'h4000_000C;
  localparam logic [31:0] A_SYS  = 32'h4000_0010;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #10 clk = ~clk;

  timer_irq_if bus ();

  timer_irq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Store: drive in the low phase, commit on the next rising edge, return at the following negedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.MemWr = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.MemWr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.MemRd = 1'b1;
    bus.addr  = a;
    #1;
    d = bus.rdata;
    bus.MemRd = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    logic [31:0] addrs [5];
    addrs = '{A_TH, A_TL, A_TCON, A_PSC, A_SYS};
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wr(A_TH, 32'h55);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h3);
    @(negedge clk);
    total++;
    if (bus.irqout !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_irq got=%b want=1", bus.irqout);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i], v);
      total++;
      if (v !== 32'h0) begin
        bad++;
        $display("FAIL reset_read addr=%h got=%h want=0", addrs[i], v);
      end
    end
    total++;
    if (bus.irqout !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq got=%b want=0", bus.irqout);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd(A_TL, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL reset_tl_frozen got=%h want=0", v);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    logic [31:0] exp_tl [4];
    exp_tl = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    @(negedge clk);
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFC);
    wr(A_TCON, 32'h3);
    rd(A_TL, v);
    total++;
    if (v !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL ovf_tl_start got=%h want=fffffffc", v);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd(A_TL, v);
      total++;
      if (v !== exp_tl[i]) begin
        bad++;
        $display("FAIL ovf_tl step=%0d got=%h want=%h", i, v, exp_tl[i]);
      end
      total++;
      if (bus.irqout !== (i == 3)) begin
        bad++;
        $display("FAIL ovf_irq step=%0d got=%b want=%b", i, bus.irqout, (i == 3));
      end
    end
    rd(A_TCON, v);
    total++;
    if (v !== 32'h7) begin
      bad++;
      $display("FAIL ovf_tcon got=%h want=7", v);
    end
    wr(A_TCON, 32'h3);
    total++;
    if (bus.irqout !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear_irq got=%b want=0", bus.irqout);
    end
    rd(A_TCON, v);
    total++;
    if (v !== 32'h3) begin
      bad++;
      $display("FAIL ovf_clear_tcon got=%h want=3", v);
    end
    wr(A_TCON, 32'h0);
  endtask

  task automatic test_set_wins;
    logic [31:0] v;
    @(negedge clk);
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    @(negedge clk);
    rd(A_TL, v);
    total++;
    if (v !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL setwin_tl_pre got=%h want=ffffffff", v);
    end
    wr(A_TCON, 32'h3);
    total++;
    if (bus.irqout !== 1'b1) begin
      bad++;
      $display("FAIL setwin_irq got=%b want=1", bus.irqout);
    end
    rd(A_TCON, v);
    total++;
    if (v !== 32'h7) begin
      bad++;
      $display("FAIL setwin_tcon got=%h want=7", v);
    end
    rd(A_TL, v);
    total++;
    if (v !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL setwin_tl_reload got=%h want=fffffffc", v);
    end
    @(negedge clk);
    total++;
    if (bus.irqout !== 1'b1) begin
      bad++;
      $display("FAIL setwin_irq_hold got=%b want=1", bus.irqout);
    end
    wr(A_TCON, 32'h0);
    total++;
    if (bus.irqout !== 1'b0) begin
      bad++;
      $display("FAIL setwin_irq_off got=%b want=0", bus.irqout);
    end
  endtask

  task automatic test_tl_store;
    logic [31:0] v;
    @(negedge clk);
    wr(A_TH, 32'h0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    @(negedge clk);
    wr(A_TL, 32'h10);
    rd(A_TL, v);
    total++;
    if (v !== 32'h10) begin
      bad++;
      $display("FAIL tlstore_tl got=%h want=10", v);
    end
    rd(A_TCON, v);
    total++;
    if (v !== 32'h3) begin
      bad++;
      $display("FAIL tlstore_tcon got=%h want=3", v);
    end
    total++;
    if (bus.irqout !== 1'b0) begin
      bad++;
      $display("FAIL tlstore_irq got=%b want=0", bus.irqout);
    end
    @(negedge clk);
    rd(A_TL, v);
    total++;
    if (v !== 32'h11) begin
      bad++;
      $display("FAIL tlstore_next got=%h want=11", v);
    end
    wr(A_TCON, 32'h0);
  endtask

  task automatic test_th_collision;
    logic [31:0] v;
    @(negedge clk);
    wr(A_TH, 32'h5);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    @(negedge clk);
    wr(A_TH, 32'h9);
    rd(A_TL, v);
    total++;
    if (v !== 32'h5) begin
      bad++;
      $display("FAIL thcol_tl got=%h want=5", v);
    end
    rd(A_TH, v);
    total++;
    if (v !== 32'h9) begin
      bad++;
      $display("FAIL thcol_th got=%h want=9", v);
    end
    total++;
    if (bus.irqout !== 1'b1) begin
      bad++;
      $display("FAIL thcol_irq got=%b want=1", bus.irqout);
    end
    wr(A_TCON, 32'h0);
  endtask

  task automatic test_decode;
    logic [31:0] v;
    logic [31:0] psc_exp;
`ifdef TIMER_PRESCALE_EN
    psc_exp = 32'h1234;
`else
    psc_exp = 32'h0;
`endif
    @(negedge clk);
    wr(A_TH, 32'hCAFE);
    rd(32'h4000_0018, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL dec_unmapped got=%h want=0", v);
    end
    rd(32'h1000_0000, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL dec_outside got=%h want=0", v);
    end
    bus.addr = A_TH;
    #1;
    total++;
    if (bus.rdata !== 32'h0) begin
      bad++;
      $display("FAIL dec_no_rd got=%h want=0", bus.rdata);
    end
    @(negedge clk);
    wr(A_TCON, 32'hFFFF_FFF8);
    rd(A_TCON, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL dec_tcon_hi got=%h want=0", v);
    end
    wr(A_PSC, 32'hABCD_1234);
    rd(A_PSC, v);
    total++;
    if (v !== psc_exp) begin
      bad++;
      $display("FAIL dec_psc got=%h want=%h", v, psc_exp);
    end
    wr(A_PSC, 32'h0);
  endtask

  task automatic test_systick;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
    @(negedge clk);
    rd(A_SYS, s0);
    wr(A_SYS, 32'h0);
    rd(A_SYS, s1);
    total++;
    if (s1 !== s0 + 32'd1) begin
      bad++;
      $display("FAIL systick_store got=%h want=%h", s1, s0 + 32'd1);
    end
    @(negedge clk);
    rd(A_SYS, s2);
    total++;
    if (s2 !== s1 + 32'd1) begin
      bad++;
      $display("FAIL systick_b2b got=%h want=%h", s2, s1 + 32'd1);
    end
  endtask

`ifdef TIMER_PRESCALE_EN
  task automatic test_prescale;
    logic [31:0] v;
    logic [31:0] e;
    @(negedge clk);
    wr(A_TH, 32'h100);
    wr(A_PSC, 32'h3);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e = (k < 4) ? 32'hFFFF_FFFE : (k < 8) ? 32'hFFFF_FFFF : 32'h100;
      rd(A_TL, v);
      total++;
      if (v !== e) begin
        bad++;
        $display("FAIL psc_tl k=%0d got=%h want=%h", k, v, e);
      end
      total++;
      if (bus.irqout !== (k == 8)) begin
        bad++;
        $display("FAIL psc_irq k=%0d got=%b want=%b", k, bus.irqout, (k == 8));
      end
    end
    wr(A_TCON, 32'h0);
  endtask
`endif

  initial begin
    bus.MemRd = 1'b0;
    bus.MemWr = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    test_reset();
    test_overflow();
    test_set_wins();
    test_tl_store();
    test_th_collision();
    test_decode();
    test_systick();
`ifdef TIMER_PRESCALE_EN
    test_prescale();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
